// File: rtl/estagio_busca_if.sv
// Instruction-memory bus between the fetch stage (master) and the memory (slave).
// Purely combinational: the memory answers instrucao for the current endereco.
// No handshake; the memory is assumed to always respond in the same cycle.
interface estagio_busca_if;
  logic [31:0] endereco;
  logic [31:0] instrucao;

  modport master (output endereco, input instrucao);
  modport slave  (input endereco, output instrucao);
endinterface

// File: rtl/estagio_busca.sv
// Instruction fetch stage: owns the PC, drives instruction memory, fills IF/ID.
// Latency: 1 cycle from PC to IF/ID; taken redirect costs exactly one bubble.
// Backpressure: stall freezes PC and IF/ID; optional counters via ESTAGIO_BUSCA_CONTADOR_EN.
module estagio_busca #(
  parameter logic [31:0] PC_INICIAL = 32'd0,
  parameter int unsigned PALAVRAS   = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  estagio_busca_if.master        imem,
  input  logic                   stall,
  input  logic                   desvio,
  input  logic [31:0]            alvo,
  output logic [31:0]            if_id_instrucao,
  output logic [31:0]            if_id_pc4,
  output logic                   if_id_valido,
  output logic                   fim,
  output logic [15:0]            cont_busca,
  output logic [15:0]            cont_bolha
);

  typedef enum logic [1:0] {
    INICIO = 2'd0,
    BUSCA  = 2'd1,
    FIM    = 2'd2
  } estado_t;

  // First byte address past the last memory word.
  localparam logic [31:0] FIM_MEM = 32'(PALAVRAS * 4);

  estado_t     estado_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic [31:0] pc4_q;
  logic        valido_q;
  logic        fim_q;

  // Targets are forced onto a word boundary; the low bits are dropped on purpose.
  logic [31:0] alvo_al;
  logic [31:0] pc_mais4;
  logic        unused_alvo;

  assign alvo_al     = {alvo[31:2], 2'b00};
  assign pc_mais4    = pc_q + 32'd4;
  assign unused_alvo = ^alvo[1:0];

  // Fetch FSM: PC, IF/ID register and end-of-memory flag, all registered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= INICIO;
      pc_q     <= PC_INICIAL;
      inst_q   <= 32'd0;
      pc4_q    <= 32'd0;
      valido_q <= 1'b0;
      fim_q    <= 1'b0;
    end else begin
      case (estado_q)
        INICIO: begin
          // Settle cycle: inputs are ignored, nothing is captured.
          estado_q <= BUSCA;
        end
        BUSCA: begin
          if (desvio) begin
            // Redirect wins over stall; the word in flight is squashed.
            pc_q     <= alvo_al;
            inst_q   <= 32'd0;
            valido_q <= 1'b0;
            if (alvo_al >= FIM_MEM) begin
              estado_q <= FIM;
              fim_q    <= 1'b1;
            end
          end else if (!stall) begin
            inst_q   <= imem.instrucao;
            pc4_q    <= pc_mais4;
            valido_q <= 1'b1;
            pc_q     <= pc_mais4;
            if (pc_mais4 >= FIM_MEM) begin
              estado_q <= FIM;
              fim_q    <= 1'b1;
            end
          end
        end
        FIM: begin
          // Halted: feed bubbles until a redirect lands back inside memory.
          inst_q   <= 32'd0;
          valido_q <= 1'b0;
          if (desvio && (alvo_al < FIM_MEM)) begin
            pc_q     <= alvo_al;
            estado_q <= BUSCA;
            fim_q    <= 1'b0;
          end
        end
        default: begin
          estado_q <= INICIO;
          pc_q     <= PC_INICIAL;
          inst_q   <= 32'd0;
          valido_q <= 1'b0;
          fim_q    <= 1'b0;
        end
      endcase
    end
  end

  assign imem.endereco   = pc_q;
  assign if_id_instrucao = inst_q;
  assign if_id_pc4       = pc4_q;
  assign if_id_valido    = valido_q;
  assign fim             = fim_q;

`ifdef ESTAGIO_BUSCA_CONTADOR_EN
  logic [15:0] cont_busca_q, cont_busca_d;
  logic [15:0] cont_bolha_q, cont_bolha_d;
  logic        ev_busca;
  logic        ev_bolha;

  // Event decode and saturating next-state for the performance counters.
  always_comb begin
    ev_busca = 1'b0;
    ev_bolha = 1'b0;
    if (estado_q == BUSCA) begin
      ev_busca = !desvio && !stall;
      ev_bolha = desvio || stall;
    end else if (estado_q == FIM) begin
      ev_bolha = 1'b1;
    end
    cont_busca_d = cont_busca_q;
    cont_bolha_d = cont_bolha_q;
    if (ev_busca && (cont_busca_q != 16'hFFFF)) cont_busca_d = cont_busca_q + 16'd1;
    if (ev_bolha && (cont_bolha_q != 16'hFFFF)) cont_bolha_d = cont_bolha_q + 16'd1;
  end

  // Counter registers, cleared with the rest of the stage.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cont_busca_q <= 16'd0;
      cont_bolha_q <= 16'd0;
    end else begin
      cont_busca_q <= cont_busca_d;
      cont_bolha_q <= cont_bolha_d;
    end
  end

  assign cont_busca = cont_busca_q;
  assign cont_bolha = cont_bolha_q;
`else
  assign cont_busca = 16'd0;
  assign cont_bolha = 16'd0;
`endif

endmodule
